axis_pdm_cic_decimator: RTL
===========================

Name: axis_pdm_cic_decimator

Overview:
Multi-channel CIC decimator directly downstream of the PDM capture stage. Consumes the 1-bit-per-channel PDM stream, a beat of one bit per microphone per pdm_clk when valid. Produces 16-bit signed PCM samples on an AXI-Stream master, one word per channel per output frame. Integrators run in parallel per channel; combs are time-multiplexed one channel per cycle, and results are buffered in an output FIFO.

Parameters:
NUM_CHANNELS, 8, number of PDM channels (2 per mic pair); bit c of s_axis_tdata is channel c
S_AXIS_BYTES, 1, input tdata width in bytes; 8*S_AXIS_BYTES >= NUM_CHANNELS, upper bits ignored
CIC_ORDER, 4, number of integrator stages and number of comb stages
DECIMATION, 64, valid input beats per output frame; power of two, > NUM_CHANNELS+1
OUT_WIDTH, 16, output sample width
FIFO_DEPTH, 16, output FIFO words; power of two, >= NUM_CHANNELS

Parameters, derived:
- W = CIC_ORDER*log2(DECIMATION)+2, which is 26 at defaults.
- SHIFT = W-1-OUT_WIDTH, which is 9 at defaults.

Ports:
pdm_clk  in  1  clock (PDM bit clock, 4.8 MHz)
io_reset  in  1  reset
s_axis_tvalid  in  1  input beat valid (no tready; every valid beat must be accepted)
s_axis_tdata  in  8*S_AXIS_BYTES  one PDM bit per channel
m_axis_tvalid  out  1  output sample valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  OUT_WIDTH  signed PCM sample
m_axis_tuser  out  clog2(NUM_CHANNELS)  channel index of the sample
m_axis_tlast  out  1  high on channel NUM_CHANNELS-1 (end of frame)
overflow  out  1  sticky: at least one frame dropped since reset
drop_count  out  16  frames dropped, saturates at 0xFFFF

Behaviour:
- Reset is io_reset, asynchronous, active-high; clock is pdm_clk.
- Reset state:
  - All integrators, comb delays, snapshot, decimation counter, FIFO pointers, overflow, drop_count and the warm-up counter clear to 0.
  - FSM returns to IDLE.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
- Input mapping: bit 1 maps to +1, bit 0 maps to -1, as W-bit two's complement.
- Integrators:
  - On each cycle with s_axis_tvalid=1, all CIC_ORDER stages of every channel update: I1+=x, Ik+=I(k-1) using pre-update values, standard pipelined chain.
  - With s_axis_tvalid=0, all integrators hold.
  - Arithmetic is modulo 2^W; wrap-around is intended and is cancelled by the combs.
- Decimation counter:
  - Counts valid beats 0..DECIMATION-1.
  - On the valid beat where the count equals DECIMATION-1, the last-stage integrator value of every channel (post-update) is latched into the snapshot bank, the count wraps to 0, and the FSM is triggered.
- FSM states:
  - IDLE to COMB on trigger.
  - COMB processes channel ch = 0..NUM_CHANNELS-1, one channel per cycle. In each cycle it runs all CIC_ORDER comb stages for that channel combinationally (Ck = in - delay_k[ch], then delay_k[ch] <= in).
  - After the last channel, COMB returns to IDLE.
  - COMB never overlaps the next trigger, guaranteed by the DECIMATION constraint.
- Output scaling:
  - sample = acc >>> SHIFT (arithmetic shift).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Full-scale +2^24 gives 32767; full-scale -2^24 gives -32768.
- Frame admission:
  - Decided at the trigger cycle. If FIFO free space < NUM_CHANNELS, the whole frame is dropped: no partial frames, combs still update, overflow is set, and drop_count increments.
  - If a FIFO pop occurs in the same cycle as the check, the pre-pop occupancy is used.
- Warm-up: the first CIC_ORDER frames after reset are computed but not pushed, and are not counted as drops.
- Output FIFO:
  - Entries are {tlast, tuser, tdata}, first-word-fall-through.
  - A transfer occurs when tvalid&&tready.
  - Push and pop in the same cycle are both honoured.
  - m_axis_tvalid is high exactly when the FIFO is non-empty.
- Latency, FIFO empty: for a trigger in cycle k, the channel-c sample is presented on m_axis at cycle k+2+c.

Test Plan:
- s_axis_tdata=0xFF, tvalid=1 continuously, tready=1 -> no output for the first 4 frames (256 beats); then every word is 32767, tuser runs 0..7 with tlast only on 7, and frames are 64 cycles apart.
- tdata=0x0F constant -> after warm-up, ch0-3 = 32767 and ch4-7 = -32768 (verifies bit-to-channel order).
- tdata alternating 0xFF/0x00 each beat -> every steady-state sample is exactly 0 on all channels.
- Same as the first scenario but tvalid toggling every cycle -> identical sample values, frame period 128 cycles, integrators hold on tvalid=0.
- tready=0 after warm-up -> 2 frames (16 words) held; the 3rd frame is dropped whole, overflow=1, drop_count=1. Releasing tready yields 16 words in order with no corruption; the next frame resumes intact.
- Assert io_reset in mid-COMB (channel 3) -> m_axis_tvalid=0 immediately, all state cleared. After release, warm-up restarts: 4 frames are suppressed before the first output.

Source files
------------

// File: rtl/axis_pdm_cic_decimator.sv
// Multi-channel PDM-to-PCM CIC decimator: parallel per-channel integrators,
// one time-multiplexed comb chain, and an FWFT output FIFO on an AXI-Stream master.

module cic_integ_lane #(
  parameter int W     = 26,
  parameter int ORDER = 4
) (
  input  logic         pdm_clk,
  input  logic         io_reset,
  input  logic         en,
  input  logic         pdm_bit,
  output logic [W-1:0] last_nxt
);
  logic [ORDER-1:0][W-1:0] integ, integ_nxt;

  // Each stage adds the previous stage's pre-update value; the last stage's
  // next value is what the snapshot captures on the trigger beat.
  always_comb begin
    integ_nxt[0] = integ[0] + (pdm_bit ? W'(1) : {W{1'b1}});
    for (int k = 1; k < ORDER; k++) integ_nxt[k] = integ[k] + integ[k-1];
  end

  assign last_nxt = integ_nxt[ORDER-1];

  always_ff @(posedge pdm_clk or posedge io_reset)
    if (io_reset)  integ <= '0;
    else if (en)   integ <= integ_nxt;
endmodule

module axis_pdm_cic_decimator #(
  parameter int NUM_CHANNELS = 8,
  parameter int S_AXIS_BYTES = 1,
  parameter int CIC_ORDER    = 4,
  parameter int DECIMATION   = 64,
  parameter int OUT_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 16,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      pdm_clk,
  input  logic                      io_reset,
  input  logic                      s_axis_tvalid,
  input  logic [8*S_AXIS_BYTES-1:0] s_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [OUT_WIDTH-1:0]      m_axis_tdata,
  output logic [CH_W-1:0]           m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      overflow,
  output logic [15:0]               drop_count
);
  localparam int W     = CIC_ORDER * $clog2(DECIMATION) + 2;
  localparam int SHIFT = W - 1 - OUT_WIDTH;
  localparam int CNT_W = $clog2(DECIMATION);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int WU_W  = $clog2(CIC_ORDER + 1);
  localparam logic signed [W-1:0] SAT_HI = W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic {IDLE, COMB} state_t;

  typedef struct packed {
    logic                 last;
    logic [CH_W-1:0]      user;
    logic [OUT_WIDTH-1:0] data;
  } fifo_word_t;

  // ---------------- integrators + decimation ----------------
  logic [NUM_CHANNELS-1:0][W-1:0] last_nxt, snap;
  logic [CNT_W-1:0]               dec_cnt;
  logic                           trigger;

  cic_integ_lane #(.W(W), .ORDER(CIC_ORDER)) u_lane [NUM_CHANNELS-1:0] (
    .pdm_clk  (pdm_clk),
    .io_reset (io_reset),
    .en       (s_axis_tvalid),
    .pdm_bit  (s_axis_tdata[NUM_CHANNELS-1:0]),
    .last_nxt (last_nxt)
  );

  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;

  assign trigger = s_axis_tvalid && (dec_cnt == CNT_W'(DECIMATION - 1));

  always_ff @(posedge pdm_clk or posedge io_reset)
    if (io_reset) begin
      dec_cnt <= '0;
      snap    <= '0;
    end else if (s_axis_tvalid) begin
      dec_cnt <= dec_cnt + CNT_W'(1);
      if (trigger) snap <= last_nxt;
    end

  // ---------------- FSM ----------------
  state_t          state, state_d;
  logic [CH_W-1:0] ch, ch_d;

  always_ff @(posedge pdm_clk or posedge io_reset)
    if (io_reset) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_d;
      ch    <= ch_d;
    end

  always_comb begin
    state_d = state;
    ch_d    = ch;
    case (state)
      IDLE: if (trigger) begin
        state_d = COMB;
        ch_d    = '0;
      end
      COMB: if (ch == CH_W'(NUM_CHANNELS - 1)) state_d = IDLE;
            else ch_d = ch + CH_W'(1);
      default: state_d = IDLE;
    endcase
  end

  // ---------------- comb chain (one channel per cycle) ----------------
  logic [CIC_ORDER-1:0][NUM_CHANNELS-1:0][W-1:0] comb_dly;
  logic [CIC_ORDER-1:0][W-1:0]                   stg_in;
  logic [W-1:0]                                  comb_t, acc;

  always_comb begin
    comb_t = snap[ch];
    for (int k = 0; k < CIC_ORDER; k++) begin
      stg_in[k] = comb_t;
      comb_t    = comb_t - comb_dly[k][ch];
    end
    acc = comb_t;
  end

  always_ff @(posedge pdm_clk or posedge io_reset)
    if (io_reset) comb_dly <= '0;
    else if (state == COMB)
      for (int k = 0; k < CIC_ORDER; k++) comb_dly[k][ch] <= stg_in[k];

  logic signed [W-1:0]  acc_sh;
  logic [OUT_WIDTH-1:0] sample;

  assign acc_sh = $signed(acc) >>> SHIFT;

  always_comb begin
    if (acc_sh > SAT_HI)      sample = SAT_HI[OUT_WIDTH-1:0];
    else if (acc_sh < SAT_LO) sample = SAT_LO[OUT_WIDTH-1:0];
    else                      sample = acc_sh[OUT_WIDTH-1:0];
  end

  // ---------------- frame admission ----------------
  logic [AW:0]     fcount, ffree;
  logic [WU_W-1:0] warm_cnt;
  logic            frame_keep;

  assign ffree = (AW+1)'(FIFO_DEPTH) - fcount;

  // Whole-frame decision made once at trigger so a frame is never split.
  always_ff @(posedge pdm_clk or posedge io_reset)
    if (io_reset) begin
      warm_cnt   <= '0;
      frame_keep <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (trigger) begin
      if (warm_cnt != WU_W'(CIC_ORDER)) begin
        warm_cnt   <= warm_cnt + WU_W'(1);
        frame_keep <= 1'b0;
      end else if (ffree < (AW+1)'(NUM_CHANNELS)) begin
        frame_keep <= 1'b0;
        overflow   <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else begin
        frame_keep <= 1'b1;
      end
    end

  // ---------------- output FIFO ----------------
  fifo_word_t    mem [FIFO_DEPTH];
  fifo_word_t    push_word, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign push           = (state == COMB) && frame_keep;
  assign pop            = m_axis_tvalid && m_axis_tready;
  assign push_word.last = (ch == CH_W'(NUM_CHANNELS - 1));
  assign push_word.user = ch;
  assign push_word.data = sample;

  always_ff @(posedge pdm_clk)
    if (push) mem[wr_ptr] <= push_word;

  always_ff @(posedge pdm_clk or posedge io_reset)
    if (io_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fcount <= fcount + (AW+1)'(1);
        2'b01:   fcount <= fcount - (AW+1)'(1);
        default: fcount <= fcount;
      endcase
    end

  assign head          = (fcount != '0) ? mem[rd_ptr] : '0;
  assign m_axis_tvalid = (fcount != '0);
  assign m_axis_tdata  = head.data;
  assign m_axis_tuser  = head.user;
  assign m_axis_tlast  = head.last;
endmodule
